// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the register-file write-back path.
//   DW / AW / NREG : register word width, register address width, register count.
//   wb_req_t       : one write-back request (valid, destination, data), used by
//                    the execute and memory stages and by the write-back arbiter.
//   port_id_t      : identifies a write-back producer port.
package regfile_pkg;

  localparam int DW   = 16;
  localparam int AW   = 3;
  localparam int NREG = 1 << AW;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_req_t;

  typedef enum logic {
    PORT_ALU = 1'b0,
    PORT_MEM = 1'b1
  } port_id_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   clk, rst_n : clock and synchronous active-low reset.
//   req[1:0]   : request per port (bit 0 = ALU, bit 1 = load unit).
//   gnt[1:0]   : one-hot grant, combinational from req and the last-grant register.
// The last-grant register only moves on a grant. Under contention the port that
// did not win last time is chosen, so its reset value (ALU) hands the first
// contention to the load unit.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  port_id_t last_reg;
  port_id_t last_next;
  port_id_t win;

  always_comb begin
    win       = PORT_ALU;
    gnt       = 2'b00;
    last_next = last_reg;
    unique case (req)
      2'b01:   win = PORT_ALU;
      2'b10:   win = PORT_MEM;
      2'b11:   win = (last_reg == PORT_ALU) ? PORT_MEM : PORT_ALU;
      default: win = PORT_ALU;
    endcase
    if (req != 2'b00) begin
      gnt       = (win == PORT_MEM) ? 2'b10 : 2'b01;
      last_next = win;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_reg <= PORT_ALU;
    end else begin
      last_reg <= last_next;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file's single write port between the
// ALU (port 0) and the load unit (port 1) and keeps a per-register busy
// scoreboard for the issue stage.
//   clk, rst_n                      : clock, synchronous active-low reset.
//   wb0_valid/reg/data, wb0_ready   : ALU write-back request and acceptance.
//   wb1_valid/reg/data, wb1_ready   : load-unit write-back request and acceptance.
//   issue_valid/reg, issue_ready    : destination allocation from issue.
//   rf_write_en/rf_wreg/rf_writedata: registered write port to the register file.
//   busy[NREG-1:0]                  : bit i set while register i awaits its write.
module regfile_wb_arbiter #(
  parameter int DW   = regfile_pkg::DW,
  parameter int AW   = regfile_pkg::AW,
  parameter int NREG = regfile_pkg::NREG
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb0_valid,
  input  logic [AW-1:0]   wb0_reg,
  input  logic [DW-1:0]   wb0_data,
  output logic            wb0_ready,
  input  logic            wb1_valid,
  input  logic [AW-1:0]   wb1_reg,
  input  logic [DW-1:0]   wb1_data,
  output logic            wb1_ready,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_reg,
  output logic            issue_ready,
  output logic            rf_write_en,
  output logic [AW-1:0]   rf_wreg,
  output logic [DW-1:0]   rf_writedata,
  output logic [NREG-1:0] busy
);

  regfile_pkg::wb_req_t req0;
  regfile_pkg::wb_req_t req1;
  regfile_pkg::wb_req_t sel;
  logic [1:0]           gnt;

  logic                 rf_write_en_reg;
  logic [AW-1:0]        rf_wreg_reg;
  logic [DW-1:0]        rf_writedata_reg;
  logic [NREG-1:0]      busy_reg;
  logic [NREG-1:0]      busy_next;

  assign req0 = '{valid: wb0_valid, rd: wb0_reg, data: wb0_data};
  assign req1 = '{valid: wb1_valid, rd: wb1_reg, data: wb1_data};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({req1.valid, req0.valid}),
    .gnt   (gnt)
  );

  assign wb0_ready = gnt[0];
  assign wb1_ready = gnt[1];

  // Winning request; an all-zero request (valid=0) when nothing is granted.
  always_comb begin
    sel = '0;
    if (gnt[1]) begin
      sel = req1;
    end else if (gnt[0]) begin
      sel = req0;
    end
  end

  // Output stage: address/data only move on a grant so the port holds its
  // last values between writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_write_en_reg  <= 1'b0;
      rf_wreg_reg      <= '0;
      rf_writedata_reg <= '0;
    end else begin
      rf_write_en_reg <= sel.valid;
      if (sel.valid) begin
        rf_wreg_reg      <= sel.rd;
        rf_writedata_reg <= sel.data;
      end
    end
  end

  // A busy register may be re-allocated in the very cycle its retiring write
  // is on the port, since that write clears the bit on the same edge.
  always_comb begin
    issue_ready = issue_valid &&
                  (!busy_reg[issue_reg] ||
                   (rf_write_en_reg && (rf_wreg_reg == issue_reg)));
  end

  // Per-register scoreboard update: a new allocation beats the retiring
  // write-back on the same register so the new producer stays tracked.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_busy
      assign busy_next[gi] =
        (issue_ready && (issue_reg == AW'(gi)))          ? 1'b1 :
        (rf_write_en_reg && (rf_wreg_reg == AW'(gi)))    ? 1'b0 :
                                                           busy_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign rf_write_en  = rf_write_en_reg;
  assign rf_wreg      = rf_wreg_reg;
  assign rf_writedata = rf_writedata_reg;
  assign busy         = busy_reg;

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back controller for the 8×16 register file. It shares the register file's single write port (write_en / wreg / writedata) between two producers, the ALU (port 0) and the load/memory unit (port 1), using round-robin arbitration and a valid/ready handshake. It also keeps a per-register busy scoreboard: the issue stage marks destination registers busy, and the arbiter clears them as their write-backs retire. The block sits between the execute/memory stages and the register file write port, and supplies hazard status to issue.

## Interface
Parameters:
- DW, 16, data width (matches register file word).
- AW, 3, register address width.
- NREG, 8, number of registers (2**AW).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset, sampled on posedge clk.
- wb0_valid  in  1  ALU write-back request.
- wb0_reg  in  AW  ALU destination register.
- wb0_data  in  DW  ALU result.
- wb0_ready  out  1  ALU request accepted this cycle.
- wb1_valid / wb1_reg / wb1_data / wb1_ready  same as wb0_*, for the load unit.
- issue_valid  in  1  issue stage allocating a destination.
- issue_reg  in  AW  destination being allocated.
- issue_ready  out  1  allocation accepted this cycle.
- rf_write_en  out  1  to register file write_en.
- rf_wreg  out  AW  to register file wreg.
- rf_writedata  out  DW  to register file writedata.
- busy  out  NREG  scoreboard; bit i = register i has a pending write.

## Operation
- A handshake completes on a port when valid && ready are both high in the same cycle. Ready depends combinationally on the valids and the internal state only, never on the data.
- Arbitration: at most one write-back grant per cycle.
  - One valid requester: it is granted.
  - Both valid: the port other than last_grant wins.
  - last_grant is a 1-bit register, updated only on a grant. Reset value 0, so port 1 wins the first contention.
- A valid request must hold its reg and data stable until ready. The arbiter never drops a request.
- Output stage: a grant in cycle N loads rf_write_en=1, rf_wreg and rf_writedata into registers, visible in cycle N+1. With no grant, rf_write_en=0 and rf_wreg/rf_writedata hold their previous values.
- Scoreboard: busy[NREG-1:0] is a register.
  - Clear: on each posedge where rf_write_en=1, bit rf_wreg is cleared.
  - Set: an accepted issue sets bit issue_reg.
  - Same register, same edge: set wins, so a new producer replaces the retiring one.
  - issue_ready = issue_valid && (!busy[issue_reg] || (rf_write_en && rf_wreg==issue_reg)).
  - Write-backs to non-busy registers are legal. The register file is written and busy is unchanged.
- No arithmetic. Addresses are used as indices only; there is no wrap logic.

## Timing
- Reset values: rf_write_en=0, rf_wreg=0, rf_writedata=0, busy=0, last_grant=0. The ready outputs follow their combinational equations from the state after reset, so wb*_ready=0 and issue_ready=0 while the corresponding valid is low.
- Reset mid-operation: any write latched in the output stage is discarded (rf_write_en=0 on the next cycle) and all busy bits are cleared. Producers must re-present their requests after reset.
- Latency:
  - Grant edge to rf_write_en high: 1 cycle.
  - Register file updated at the end of that cycle.
  - The busy bit clears at the same edge, so issue can re-allocate that register in the cycle the write pulse is visible.
- Throughput: one write-back per cycle sustained. Under continuous contention the ports alternate strictly.
- Simultaneous grant and write to the same register from successive cycles: the later write lands last, and the register file holds the later data.

## Structure
- Shared package regfile_pkg: DW, AW, NREG constants, plus a wb_req struct (valid, reg, data) reused by the execute and memory stages.
- One natural sub-module: rr_arb2, a 2-way round-robin arbiter with a last-grant register and one-hot grant output. The output stage and scoreboard stay in the top module.

## Test plan
- Reset, then wb0 only, reg 3, data 0x00A5 → wb0_ready=1 same cycle; next cycle rf_write_en=1, rf_wreg=3, rf_writedata=0x00A5.
- Both ports valid for 4 cycles (reg1/0x1111, reg2/0x2222, held until ready) → grants in order port1, port0, port1, port0; each rf write appears 1 cycle after its grant.
- Issue reg 5, then issue reg 5 again → second issue_ready=0 until the wb0 write to reg 5 is on rf_write_en; in that cycle issue_ready=1, and busy[5] is still 1 afterwards (set wins).
- Issue reg 2 and reg 6 → busy=0x44; wb1 writes reg 6, then wb0 writes reg 2 → busy goes 0x04, then 0x00.
- Assert rst_n=0 in the cycle after a grant → next cycle rf_write_en=0, busy=0; the register file is not written.
- Write-back to reg 7 with busy[7]=0 → register file written, busy stays 0.
